// File: rtl/data_in_top_level.sv
// I2C slave receive-path decoder: captures bytes MSB-first, drives the ACK pull-down, stores nibbles per byte.
// Optional DATA_IN_BYTE_OUT_EN adds byte_out holding each full received byte.
module data_in_top_level #(
  parameter int NUM_BYTES = 6
) (
  input  logic                   FPGA_clk,
  input  logic                   rst,
  input  logic                   SCL,
  input  logic                   SCL_prev,
  input  logic                   SDA,
  input  logic                   SDA_prev,
  input  logic                   enable,
  output logic                   done,
  output logic                   SDA_down,
`ifdef DATA_IN_BYTE_OUT_EN
  output logic [8*NUM_BYTES-1:0] byte_out,
`endif
  output logic [4*NUM_BYTES-1:0] HEX_out
);

  localparam int IDX_W = $clog2(NUM_BYTES + 1);

  typedef enum logic [1:0] {
    S_RECV,
    S_ACK_WAIT,
    S_ACK_HOLD,
    S_DONE
  } state_t;

  state_t                   r_state;
  logic [2:0]               r_bit_cnt;
  logic [IDX_W-1:0]         r_byte_idx;
  logic [7:0]               r_shift;
  logic                     r_done;
  logic                     r_sda_down;
  logic [4*NUM_BYTES-1:0]   r_hex;
`ifdef DATA_IN_BYTE_OUT_EN
  logic [8*NUM_BYTES-1:0]   r_byte;
`endif

  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  assign w_scl_rise = SCL & ~SCL_prev;
  assign w_scl_fall = ~SCL & SCL_prev;
  assign w_start    = SCL & SCL_prev & SDA_prev & ~SDA;
  assign w_stop     = SCL & SCL_prev & ~SDA_prev & SDA;

  always_ff @(posedge FPGA_clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_RECV;
      r_bit_cnt  <= '0;
      r_byte_idx <= '0;
      r_shift    <= '0;
      r_done     <= 1'b0;
      r_sda_down <= 1'b0;
      r_hex      <= '0;
`ifdef DATA_IN_BYTE_OUT_EN
      r_byte     <= '0;
`endif
    end else if (!enable) begin
      r_bit_cnt  <= '0;
      r_sda_down <= 1'b0;
      if (r_state != S_DONE) r_state <= S_RECV;
    end else if ((w_start || w_stop) && (r_state != S_DONE)) begin
      // Bus condition wins over any same-cycle SCL edge; committed bytes survive.
      r_bit_cnt  <= '0;
      r_sda_down <= 1'b0;
      r_state    <= S_RECV;
    end else begin
      case (r_state)
        S_RECV: begin
          if (w_scl_rise) begin
            r_shift <= {r_shift[6:0], SDA};
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= '0;
              r_state   <= S_ACK_WAIT;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
        end
        S_ACK_WAIT: begin
          if (w_scl_fall) begin
            r_sda_down <= 1'b1;
            r_state    <= S_ACK_HOLD;
          end
        end
        S_ACK_HOLD: begin
          // This fall ends the 9th pulse: release SDA and commit the byte.
          if (w_scl_fall) begin
            r_sda_down <= 1'b0;
            for (int k = 0; k < NUM_BYTES; k++) begin
              if (r_byte_idx == IDX_W'(k)) begin
                r_hex[4*k +: 4] <= r_shift[3:0];
`ifdef DATA_IN_BYTE_OUT_EN
                r_byte[8*k +: 8] <= r_shift;
`endif
              end
            end
            r_byte_idx <= r_byte_idx + 1'b1;
            if (r_byte_idx == IDX_W'(NUM_BYTES - 1)) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_RECV;
            end
          end
        end
        S_DONE: begin
          r_sda_down <= 1'b0;
        end
        default: r_state <= S_RECV;
      endcase
    end
  end

  assign done     = r_done;
  assign SDA_down = r_sda_down;
  assign HEX_out  = r_hex;
`ifdef DATA_IN_BYTE_OUT_EN
  assign byte_out = r_byte;
`endif

endmodule

// File: tb/tb_data_in_top_level.sv
// Scoreboard bench for data_in_top_level: randomized I2C master traffic against a slot-array reference model.
module tb_data_in_top_level;
  localparam int N = 6;

  logic           clk = 1'b0;
  logic           rst;
  logic           scl, scl_p, sda, sda_p, en;
  logic           done, sdd;
  logic [4*N-1:0] hex;
`ifdef DATA_IN_BYTE_OUT_EN
  logic [8*N-1:0] bo;
`endif

  always #5 clk = ~clk;

  initial begin
    scl_p = 1'b1;
    sda_p = 1'b1;
  end
  always @(posedge clk) begin
    scl_p <= scl;
    sda_p <= sda;
  end

  data_in_top_level #(.NUM_BYTES(N)) dut (
    .FPGA_clk (clk),
    .rst      (rst),
    .SCL      (scl),
    .SCL_prev (scl_p),
    .SDA      (sda),
    .SDA_prev (sda_p),
    .enable   (en),
    .done     (done),
    .SDA_down (sdd),
`ifdef DATA_IN_BYTE_OUT_EN
    .byte_out (bo),
`endif
    .HEX_out  (hex)
  );

  typedef struct {
    logic [4*N-1:0] hex;
    logic           done;
  } exp_t;

  exp_t       q[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         h = 1;
  logic       exp_ack = 1'b0;
  logic       sdd_prev = 1'b0;
  int         m_idx = 0;
  logic [3:0] m_slot[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4*N-1:0] m_hex();
    logic [4*N-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[4*k +: 4] = m_slot[k];
    return r;
  endfunction

  task automatic m_reset();
    m_idx = 0;
    for (int k = 0; k < N; k++) m_slot[k] = 4'h0;
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    scl = 1'b0; sda = b; exp_ack = 1'b0;
    wclk(h);
    scl = 1'b1;
    wclk(h);
  endtask

  task automatic send_start();
    scl = 1'b0; sda = 1'b1; exp_ack = 1'b0;
    wclk(h);
    scl = 1'b1;
    wclk(h);
    sda = 1'b0;
    wclk(h);
  endtask

  task automatic send_stop();
    scl = 1'b0; sda = 1'b0; exp_ack = 1'b0;
    wclk(h);
    scl = 1'b1;
    wclk(h);
    sda = 1'b1;
    wclk(h);
  endtask

  // Full byte plus ACK slot; the model decides whether the slave should acknowledge.
  task automatic send_byte(input logic [7:0] d);
    exp_t e;
    logic acking;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    acking = (m_idx < N);
    if (acking) begin
      m_slot[m_idx] = d[3:0];
      m_idx++;
      e.hex  = m_hex();
      e.done = (m_idx == N);
      q.push_back(e);
    end
    scl = 1'b0; sda = 1'b1; exp_ack = acking;
    wclk(h);
    scl = 1'b1;
    wclk(h);
    scl = 1'b0; exp_ack = 1'b0;
    wclk(h);
  endtask

  // Monitor: ACK level while SCL is high, and a commit check whenever SDA_down is released.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      sdd_prev = 1'b0;
    end else begin
      if (scl === 1'b1) chk("ack_level", 64'(sdd), 64'(exp_ack));
      if (sdd_prev && !sdd) begin
        if (q.size() == 0) begin
          chk("unexpected_commit", 64'(hex), 64'(m_hex()));
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("hex_commit", 64'(hex), 64'(e.hex));
          chk("done_commit", 64'(done), 64'(e.done));
        end
      end
      sdd_prev = sdd;
    end
  end

  initial begin
    logic [7:0] r;
    logic [7:0] six[6];
    six[0] = 8'h49; six[1] = 8'h55; six[2] = 8'h92;
    six[3] = 8'h55; six[4] = 8'h24; six[5] = 8'h55;
    m_reset();
    rst = 1'b1; scl = 1'b1; sda = 1'b1; en = 1'b1; h = 1;

    // Reset state and idle bus
    wclk(1);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_sdd", 64'(sdd), 64'd0);
    chk("rst_hex", 64'(hex), 64'd0);
    rst = 1'b0;
    wclk(5);
    chk("idle_done", 64'(done), 64'd0);
    chk("idle_sdd", 64'(sdd), 64'd0);
    chk("idle_hex", 64'(hex), 64'd0);

    // Single byte 0xA5 at SCL period 20 ns
    send_start();
    send_byte(8'hA5);
    send_stop();
    chk("a5_slot0", 64'(hex[3:0]), 64'h5);

    // STOP after four bits discards the partial byte
    send_start();
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    send_stop();
    send_byte(8'h3C);
    send_stop();
    chk("abort_slot1", 64'(hex[7:4]), 64'hC);
    chk("abort_slot0", 64'(hex[3:0]), 64'h5);

    // enable low mid-byte restarts the bit count
    send_start();
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    en = 1'b0;
    for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)));
    chk("dis_hex", 64'(hex), 64'(m_hex()));
    en = 1'b1;
    r = 8'($urandom);
    send_byte(r);
    send_stop();
    chk("en_slot2", 64'(hex[11:8]), 64'(r[3:0]));

    // Randomized traffic with aborts until done, then extra bytes past done
    for (int it = 0; it < 12; it++) begin
      h = $urandom_range(1, 3);
      if ($urandom_range(0, 3) == 0) begin
        int k;
        k = $urandom_range(1, 7);
        for (int i = 0; i < k; i++) send_bit(1'($urandom_range(0, 1)));
        send_stop();
      end else begin
        if ($urandom_range(0, 1) == 1) send_start();
        send_byte(8'($urandom));
        if ($urandom_range(0, 1) == 1) send_stop();
      end
    end
    while (m_idx < N) send_byte(8'($urandom));
    send_byte(8'($urandom));
    send_stop();
    chk("rand_done", 64'(done), 64'd1);
    chk("rand_hex", 64'(hex), 64'(m_hex()));

    // Asynchronous reset during the ACK pulse
    h = 1;
    rst = 1'b1; wclk(1); rst = 1'b0; m_reset();
    send_start();
    send_byte(8'h17);
    for (int i = 7; i >= 0; i--) send_bit(1'($urandom_range(0, 1)));
    scl = 1'b0; sda = 1'b1; exp_ack = 1'b1;
    wclk(2);
    chk("ack_pre_rst", 64'(sdd), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("ack_rst_sdd", 64'(sdd), 64'd0);
    chk("ack_rst_hex", 64'(hex), 64'd0);
    chk("ack_rst_done", 64'(done), 64'd0);
    exp_ack = 1'b0; scl = 1'b1; sda = 1'b1;
    wclk(1);
    rst = 1'b0;
    m_reset();
    wclk(2);

    // Six fixed bytes, each followed by STOP
    for (int b = 0; b < 6; b++) begin
      send_start();
      send_byte(six[b]);
      send_stop();
    end
    chk("six_hex", 64'(hex), 64'h545259);
    chk("six_done", 64'(done), 64'd1);

    wclk(3);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/data_in_top_level.md
Name: data_in_top_level

Overview:
I2C slave receive-path decoder. Oversamples SCL/SDA on the fast FPGA clock and detects SCL edges and START/STOP from current/previous samples. Shifts in bytes MSB-first, drives the ACK pull-down request, and stores the low nibble of each received byte into a per-byte HEX output slot. Sits between the I2C pin synchronisers and the display/register logic of the slave.

Parameters:
NUM_BYTES, 6, number of bytes captured per session; HEX_out holds one 4-bit slot per byte; minimum 1.

Ports:
FPGA_clk  in  1  system clock; all state changes on its rising edge.
rst  in  1  asynchronous, active-high reset.
SCL  in  1  synchronised I2C clock, current sample.
SCL_prev  in  1  SCL sampled one FPGA_clk earlier.
SDA  in  1  synchronised I2C data, current sample.
SDA_prev  in  1  SDA sampled one FPGA_clk earlier.
enable  in  1  decoder active when 1; when 0, state held idle.
done  out  1  high once NUM_BYTES bytes received; level, sticky.
SDA_down  out  1  request to pull SDA low (ACK); drives the open-drain pad logic.
HEX_out  out  4*NUM_BYTES  flat bus; bits [4k+3:4k] = low nibble of byte k (k=0 first byte).

Behaviour:
- Reset (async, rst=1): done=0, SDA_down=0, HEX_out=0, bit counter=0, byte index=0, shift register=0.
- Events per FPGA_clk (combinational from inputs): scl_rise = SCL & ~SCL_prev; scl_fall = ~SCL & SCL_prev; start = SCL & SCL_prev & SDA_prev & ~SDA; stop = SCL & SCL_prev & ~SDA_prev & SDA.
- enable=0: bit counter and SDA_down cleared next clock; byte index, HEX_out, done retained.
- States: RECV (bit counter 0..7), ACK, DONE.
- RECV: on scl_rise shift SDA into LSB of shift register (MSB-first); increment counter. On 8th bit go to ACK.
- ACK: on the first scl_fall after the 8th bit, assert SDA_down=1. Hold through the 9th SCL pulse; deassert on the next scl_fall. Then write shift[3:0] into HEX_out slot[byte index] and increment byte index. If byte index reaches NUM_BYTES set done=1 and go to DONE, else return to RECV with counter=0.
- start or stop while SCL high: bit counter cleared, SDA_down cleared, partial byte discarded; byte index and HEX_out retained. STOP does not abort a completed byte already committed.
- START/STOP detection has priority over scl_rise in the same clock.
- DONE: no further captures or ACKs; done stays 1 until rst. Byte index never wraps.
- Latency: HEX slot valid one FPGA_clk after the scl_fall that ends the ACK pulse.
- SDA_down is registered; glitch-free.

Optional Feature:
Macro DATA_IN_BYTE_OUT_EN. Defined: adds output byte_out [8*NUM_BYTES-1:0] holding full received bytes (slot k = bits [8k+7:8k]), written at the same time as HEX_out, reset to 0. Undefined: port absent, only nibbles stored.

Test Plan:
- Reset: rst=1 for one clock -> done=0, SDA_down=0, HEX_out=0; release, no SCL activity -> all unchanged.
- Single byte 0xA5 MSB-first, SCL period 20 ns, FPGA_clk period 10 ns -> SDA_down=1 during 9th SCL pulse only; HEX_out[3:0]=4'h5 after ACK.
- Six bytes 0x49,0x55,0x92,0x55,0x24,0x55, each followed by ACK slot and STOP -> HEX_out nibbles 9,5,2,5,4,5; done=1 after 6th ACK.
- STOP injected after 4 bits of byte 1 -> partial discarded; next full byte 0x3C lands in slot 1 = 4'hC; slot 0 unchanged.
- enable=0 mid-byte for 3 SCL cycles, then 1 -> no capture while low, bit counter restarts; HEX_out unchanged.
- rst asserted during ACK -> SDA_down drops immediately (async); HEX_out=0, done=0.
